pcie_dest_drain: RTL

Downstream drain stage for the PCIe transaction path. It consumes the two destination FIFOs, D0 and D1, through their `can_pop`/`pop` interface and merges them into a single registered output stream. Arbitration between the two destinations is round-robin, and the output uses a valid/ready handshake. The block also keeps saturating per-destination word counters and flags read-protocol errors.

---
 rtl/pcie_dest_drain_if.sv | 30 +++
 rtl/pcie_dest_drain.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pcie_dest_drain_if.sv
// FIFO-side read signals and merged output stream of the destination drain stage.
// The master modport is the drain itself; the slave modport is the FIFO/sink environment.
interface pcie_dest_drain_if #(
    parameter int BITNUMBER = 6
) ();
    logic [BITNUMBER-1:0] data_out0;
    logic [BITNUMBER-1:0] data_out1;
    logic                 D0_can_pop;
    logic                 D1_can_pop;
    logic                 D0_valid_read;
    logic                 D1_valid_read;
    logic                 pop_D0;
    logic                 pop_D1;
    logic [BITNUMBER-1:0] out_data;
    logic                 out_valid;
    logic                 out_dest;
    logic                 out_ready;

    modport master (
        input  data_out0, data_out1, D0_can_pop, D1_can_pop,
        input  D0_valid_read, D1_valid_read, out_ready,
        output pop_D0, pop_D1, out_data, out_valid, out_dest
    );

    modport slave (
        output data_out0, data_out1, D0_can_pop, D1_can_pop,
        output D0_valid_read, D1_valid_read, out_ready,
        input  pop_D0, pop_D1, out_data, out_valid, out_dest
    );
endinterface

// File: rtl/pcie_dest_drain.sv
// Round-robin drain of the D0/D1 destination FIFOs into one registered valid/ready stream,
// with saturating per-destination word counters and a sticky read-protocol error flag.
module pcie_dest_drain #(
    parameter int BITNUMBER = 6,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pcie_dest_drain_if.master    bus,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] cnt_D0,
    output logic [CNT_WIDTH-1:0] cnt_D1,
    output logic                 rd_err,
    output logic [1:0]           drain_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   sel_q, sel_d;
    logic                   rr_last_q, rr_last_d;
    logic                   pop_D0_q, pop_D0_d;
    logic                   pop_D1_q, pop_D1_d;
    logic [BITNUMBER-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_dest_q, out_dest_d;
    logic [CNT_WIDTH-1:0]   cnt_D0_q, cnt_D0_d;
    logic [CNT_WIDTH-1:0]   cnt_D1_q, cnt_D1_d;
    logic                   rd_err_q, rd_err_d;

    logic                   can_any;
    logic                   winner;
    logic                   vr_sel;
    logic                   vr_other;
    logic [BITNUMBER-1:0]   sel_data;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        can_any  = bus.D0_can_pop | bus.D1_can_pop;
        winner   = (bus.D0_can_pop & bus.D1_can_pop) ? ~rr_last_q : bus.D1_can_pop;
        vr_sel   = sel_q ? bus.D1_valid_read : bus.D0_valid_read;
        vr_other = sel_q ? bus.D0_valid_read : bus.D1_valid_read;
        sel_data = sel_q ? bus.data_out1 : bus.data_out0;

        state_d     = state_q;
        sel_d       = sel_q;
        rr_last_d   = rr_last_q;
        pop_D0_d    = 1'b0;
        pop_D1_d    = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_dest_d  = out_dest_q;
        cnt_D0_d    = cnt_D0_q;
        cnt_D1_d    = cnt_D1_q;
        rd_err_d    = rd_err_q;

        case (state_q)
            IDLE: begin
                if (can_any) begin
                    pop_D0_d = ~winner;
                    pop_D1_d = winner;
                    sel_d    = winner;
                    state_d  = READ;
                end
            end
            READ: begin
                if (vr_other) rd_err_d = 1'b1;
                // The first READ cycle carries the pop strobe; the FIFO answers one cycle later.
                if (!(pop_D0_q | pop_D1_q)) begin
                    if (vr_sel) begin
                        out_data_d  = sel_data;
                        out_dest_d  = sel_q;
                        out_valid_d = 1'b1;
                        rr_last_d   = sel_q;
                        state_d     = HOLD;
                        if (sel_q) cnt_D1_d = sat_inc(cnt_D1_q);
                        else       cnt_D0_d = sat_inc(cnt_D0_q);
                    end else begin
                        rd_err_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (can_any) begin
                        pop_D0_d = ~winner;
                        pop_D1_d = winner;
                        sel_d    = winner;
                        state_d  = READ;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear has priority over a coinciding increment or error.
        if (cnt_clr) begin
            cnt_D0_d = '0;
            cnt_D1_d = '0;
            rd_err_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            rr_last_q   <= 1'b1;
            pop_D0_q    <= 1'b0;
            pop_D1_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_dest_q  <= 1'b0;
            cnt_D0_q    <= '0;
            cnt_D1_q    <= '0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_last_q   <= rr_last_d;
            pop_D0_q    <= pop_D0_d;
            pop_D1_q    <= pop_D1_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_dest_q  <= out_dest_d;
            cnt_D0_q    <= cnt_D0_d;
            cnt_D1_q    <= cnt_D1_d;
            rd_err_q    <= rd_err_d;
        end
    end

    assign bus.pop_D0    = pop_D0_q;
    assign bus.pop_D1    = pop_D1_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_dest  = out_dest_q;
    assign cnt_D0        = cnt_D0_q;
    assign cnt_D1        = cnt_D1_q;
    assign rd_err        = rd_err_q;
    assign drain_state   = state_q;

endmodule
